// File: rtl/kernel_stream_pkg.sv
// rtl/kernel_stream_pkg.sv - shared types and kernel weights for kernel3x3_stream
package kernel_stream_pkg;

   typedef enum logic [1:0] {
      MODE_PASS   = 2'b00,
      MODE_SOBEL  = 2'b01,
      MODE_GAUSS  = 2'b10,
      MODE_THRESH = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACTIVE = 2'b01,
      ST_DRAIN  = 2'b10
   } state_t;

   // Row 0 is the oldest line (top of the window), column 2 the newest pixel.
   localparam logic signed [3:0] SOBEL_X [3][3] = '{
      '{-4'sd1, 4'sd0, 4'sd1},
      '{-4'sd2, 4'sd0, 4'sd2},
      '{-4'sd1, 4'sd0, 4'sd1}
   };

   localparam logic signed [3:0] SOBEL_Y [3][3] = '{
      '{-4'sd1, -4'sd2, -4'sd1},
      '{ 4'sd0,  4'sd0,  4'sd0},
      '{ 4'sd1,  4'sd2,  4'sd1}
   };

   localparam logic [2:0] GAUSS_K [3][3] = '{
      '{3'd1, 3'd2, 3'd1},
      '{3'd2, 3'd4, 3'd2},
      '{3'd1, 3'd2, 3'd1}
   };

   // Weights sum to 16: add half of that before the shift to round to nearest.
   localparam int GAUSS_ROUND = 8;
   localparam int GAUSS_SHIFT = 4;

endpackage

// File: rtl/line_buffer_2row.sv
// rtl/line_buffer_2row.sv - two cascaded row buffers with read-before-write ports
module line_buffer_2row #(
   parameter int DEPTH = 640,
   parameter int WIDTH = 8,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] row1_data,
   output logic [WIDTH-1:0] row2_data
);

   logic [WIDTH-1:0] row1_mem [DEPTH];
   logic [WIDTH-1:0] row2_mem [DEPTH];

   // Reads return the previous row's pixel at this column before it is overwritten.
   assign row1_data = row1_mem[addr];
   assign row2_data = row2_mem[addr];

   // New pixel enters row 1; the displaced row-1 pixel moves down into row 2.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         row1_mem[addr] <= wr_data;
         row2_mem[addr] <= row1_mem[addr];
      end
   end

endmodule

// File: rtl/kernel3x3_stream.sv
// rtl/kernel3x3_stream.sv - streaming 3x3 Sobel / Gaussian / threshold filter
module kernel3x3_stream
   import kernel_stream_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int PIXEL_BITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            mode,
   input  logic [PIXEL_BITS-1:0] threshold,
   input  logic [PIXEL_BITS-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [PIXEL_BITS-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_sof,
   output logic                  m_eol,
   output logic                  frame_done
);

   localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
   // Sobel gradients reach +/-4*max pixel; Gaussian sum reaches 16*max pixel + round.
   localparam int SW = PIXEL_BITS + 4;
   localparam int GW = PIXEL_BITS + 4;

   state_t state, state_next;
   mode_t  mode_q;
   logic [PIXEL_BITS-1:0] thr_q;
   logic [XW-1:0] x, cur_x;
   logic [YW-1:0] y, cur_y;
   logic en, accept, last_xfer, m_last;
   logic [PIXEL_BITS-1:0] lb_row1, lb_row2;
   logic [PIXEL_BITS-1:0] win [3][3];

   logic a_valid, a_inner, a_sof, a_eol, a_last;
   logic [PIXEL_BITS-1:0] a_pix;

   logic signed [SW-1:0] gx, gy, px_s, kx, ky;
   logic [SW-1:0] ax, ay;
   logic [SW:0]   mag;
   logic [GW-1:0] gsum;
   logic [PIXEL_BITS-1:0] mag_sat, gauss, result;

   assign en        = !m_valid || m_ready;
   assign s_ready   = !reset && en && (state != ST_DRAIN);
   assign accept    = s_valid && s_ready;
   assign last_xfer = m_valid && m_ready && m_last;

   // Position of the pixel on s_data now; the first pixel taken from IDLE is (0,0).
   always_comb begin
      cur_x = '0;
      cur_y = '0;
      if (state != ST_IDLE) begin
         if (x == X_LAST) begin
            cur_x = '0;
            cur_y = (y == Y_LAST) ? '0 : y + YW'(1);
         end else begin
            cur_x = x + XW'(1);
            cur_y = y;
         end
      end
   end

   // Frame state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Frame sequencing: start on first pixel, stop input after the last, finish on last output.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (accept) state_next = ST_ACTIVE;
         ST_ACTIVE: if (accept && cur_x == X_LAST && cur_y == Y_LAST) state_next = ST_DRAIN;
         ST_DRAIN:  if (last_xfer) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Track the newest accepted pixel and latch frame settings at its first pixel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x      <= '0;
         y      <= '0;
         mode_q <= MODE_PASS;
         thr_q  <= '0;
      end else if (accept) begin
         x <= cur_x;
         y <= cur_y;
         if (state == ST_IDLE) begin
            mode_q <= mode_t'(mode);
            thr_q  <= threshold;
         end
      end
   end

   line_buffer_2row #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (PIXEL_BITS),
      .AW    (XW)
   ) u_line_buffer (
      .clk       (clk),
      .wr_en     (accept),
      .addr      (cur_x),
      .wr_data   (s_data),
      .row1_data (lb_row1),
      .row2_data (lb_row2)
   );

   // Shift the 3x3 window left by one column per accepted pixel; stale columns are masked later.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= lb_row2;
         win[1][2] <= lb_row1;
         win[2][2] <= s_data;
      end
   end

   // Stage A: metadata travelling with the window contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_valid <= 1'b0;
         a_inner <= 1'b0;
         a_sof   <= 1'b0;
         a_eol   <= 1'b0;
         a_last  <= 1'b0;
         a_pix   <= '0;
      end else if (en) begin
         a_valid <= accept;
         if (accept) begin
            a_pix   <= s_data;
            a_inner <= (cur_x >= XW'(2)) && (cur_y >= YW'(2));
            a_sof   <= (state == ST_IDLE);
            a_eol   <= (cur_x == X_LAST);
            a_last  <= (cur_x == X_LAST) && (cur_y == Y_LAST);
         end
      end
   end

   // Kernel arithmetic on the stage-A window and selection by the latched mode.
   always_comb begin
      gx   = '0;
      gy   = '0;
      px_s = '0;
      kx   = '0;
      ky   = '0;
      gsum = GW'(GAUSS_ROUND);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            px_s = $signed({{(SW-PIXEL_BITS){1'b0}}, win[r][c]});
            kx   = $signed({{(SW-4){SOBEL_X[r][c][3]}}, SOBEL_X[r][c]});
            ky   = $signed({{(SW-4){SOBEL_Y[r][c][3]}}, SOBEL_Y[r][c]});
            gx   = gx + px_s * kx;
            gy   = gy + px_s * ky;
            gsum = gsum + {{(GW-PIXEL_BITS){1'b0}}, win[r][c]} * {{(GW-3){1'b0}}, GAUSS_K[r][c]};
         end
      end
      ax      = gx[SW-1] ? -gx : gx;
      ay      = gy[SW-1] ? -gy : gy;
      mag     = {1'b0, ax} + {1'b0, ay};
      mag_sat = (|mag[SW:PIXEL_BITS]) ? '1 : mag[PIXEL_BITS-1:0];
      gauss   = PIXEL_BITS'(gsum >> GAUSS_SHIFT);
      result  = '0;
      case (mode_q)
         MODE_PASS:   result = a_pix;
         MODE_SOBEL:  result = a_inner ? mag_sat : '0;
         MODE_GAUSS:  result = a_inner ? gauss : '0;
         MODE_THRESH: result = (a_inner && mag_sat >= thr_q) ? '1 : '0;
         default:     result = '0;
      endcase
   end

   // Stage B: output register, frozen while the sink stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_sof   <= 1'b0;
         m_eol   <= 1'b0;
         m_last  <= 1'b0;
      end else if (en) begin
         m_valid <= a_valid;
         if (a_valid) begin
            m_data <= result;
            m_sof  <= a_sof;
            m_eol  <= a_eol;
            m_last <= a_last;
         end
      end
   end

   // One-cycle pulse once the final pixel of the frame has left.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) frame_done <= 1'b0;
      else       frame_done <= last_xfer;
   end

endmodule

// File: tb/tb_kernel3x3_stream.sv
// tb/tb_kernel3x3_stream.sv - scoreboard testbench for kernel3x3_stream
`timescale 1ns/1ps
module tb_kernel3x3_stream;

   localparam int W    = 8;
   localparam int H    = 4;
   localparam int PB   = 8;
   localparam int NPIX = W * H;
   localparam int NCASE = 12;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    mode = 2'b00;
   logic [PB-1:0] threshold = '0;
   logic [PB-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [PB-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic          m_sof;
   logic          m_eol;
   logic          frame_done;

   kernel3x3_stream #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .PIXEL_BITS (PB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mode       (mode),
      .threshold  (threshold),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_sof      (m_sof),
      .m_eol      (m_eol),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PB-1:0] data;
      logic          sof;
      logic          eol;
      logic          last;
      int            acc;
      logic          timed;
   } exp_t;

   typedef struct {
      logic [1:0]    mode;
      logic [PB-1:0] thr;
      int            pattern;     // 0 constant 100, 1 vertical step, 2 random
      logic          stall;       // random s_valid gaps and m_ready
      int            switch_at;   // pixel index where the mode input changes, -1 none
      logic [1:0]    switch_mode;
      int            target;      // output value to count, -1 none
      int            exp_hits;    // required count of target, -1 none
   } case_t;

   exp_t  exp_q[$];
   exp_t  mon_e;
   case_t tc [NCASE];

   int total = 0;
   int passed = 0;
   int cyc = 0;
   int fd_count = 0;
   int hits = 0;
   int target = -1;
   logic rand_ready = 1'b0;
   logic [PB-1:0] img [H][W];

   logic          held_valid = 1'b0;
   logic [PB-1:0] held_data = '0;
   logic          held_sof = 1'b0;
   logic          held_eol = 1'b0;
   logic          expect_fd = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d required %0d", name, act, exp);
   endtask

   // Reference filter computed directly from the frame image.
   function automatic int model(input int x, input int y, input logic [1:0] md, input int thr);
      int gx, gy, g, mag, p, wr, wc;
      if (md == 2'b00) return int'(img[y][x]);
      if (x < 2 || y < 2) return 0;
      gx = 0; gy = 0; g = 0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            p  = int'(img[y-2+r][x-2+c]);
            wr = (r == 1) ? 2 : 1;
            wc = (c == 1) ? 2 : 1;
            if (c == 0) gx = gx - wr * p;
            if (c == 2) gx = gx + wr * p;
            if (r == 0) gy = gy - wc * p;
            if (r == 2) gy = gy + wc * p;
            g = g + wr * wc * p;
         end
      end
      mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
      if (mag > 255) mag = 255;
      if (md == 2'b01) return mag;
      if (md == 2'b10) return (g + 8) / 16;
      return (mag >= thr) ? 255 : 0;
   endfunction

   task automatic fill(input int pattern);
      for (int yy = 0; yy < H; yy++)
         for (int xx = 0; xx < W; xx++)
            case (pattern)
               0:       img[yy][xx] = 8'd100;
               1:       img[yy][xx] = (xx < 4) ? 8'd0 : 8'd200;
               default: img[yy][xx] = 8'($urandom_range(0, 255));
            endcase
   endtask

   task automatic send_frame(input int k, input int npix);
      int n, fd_before, x, y;
      mode       = tc[k].mode;
      threshold  = tc[k].thr;
      rand_ready = tc[k].stall;
      target     = tc[k].target;
      hits       = 0;
      fd_before  = fd_count;
      fill(tc[k].pattern);
      for (int i = 0; i < npix; i++) begin
         x = i % W;
         y = i / W;
         if (i == tc[k].switch_at) mode = tc[k].switch_mode;
         if (tc[k].stall)
            while ($urandom_range(0, 1) == 1) begin
               s_valid = 1'b0;
               @(posedge clk); #1;
            end
         s_valid = 1'b1;
         s_data  = img[y][x];
         n = 0;
         @(negedge clk);
         while (!s_ready && n < 1000) begin
            @(negedge clk);
            n++;
         end
         if (!s_ready) begin
            $display("FAIL accept_timeout: s_ready %0d required 1 (case %0d pixel %0d)", s_ready, k, i);
            $fatal(1, "bench stopped: input never accepted");
         end
         exp_q.push_back('{8'(model(x, y, tc[k].mode, int'(tc[k].thr))), (i == 0), (x == W-1),
                           (i == NPIX-1), cyc + 1, !tc[k].stall});
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      if (npix == NPIX) begin
         check("drain_s_ready", s_ready, 0);
         n = 0;
         while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
         end
         check("drain_qsize", exp_q.size(), 0);
         repeat (3) @(posedge clk);
         #1;
         if (tc[k].exp_hits >= 0) check("target_hits", hits, tc[k].exp_hits);
         check("frame_done_count", fd_count - fd_before, 1);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   // Output monitor: scoreboard pop, stall stability, frame_done timing.
   initial forever begin
      @(negedge clk);
      if (reset) begin
         held_valid = 1'b0;
         expect_fd  = 1'b0;
      end else begin
         if (frame_done) fd_count++;
         if (expect_fd) begin
            check("frame_done_after_last", frame_done, 1);
            expect_fd = 1'b0;
         end
         if (held_valid) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, held_data);
            check("stall_sof", m_sof, held_sof);
            check("stall_eol", m_eol, held_eol);
         end
         held_valid = m_valid && !m_ready;
         held_data  = m_data;
         held_sof   = m_sof;
         held_eol   = m_eol;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_output_qsize", exp_q.size(), 1);
            end else begin
               mon_e = exp_q.pop_front();
               check("m_data", m_data, mon_e.data);
               check("m_sof", m_sof, mon_e.sof);
               check("m_eol", m_eol, mon_e.eol);
               if (mon_e.timed) check("latency_cycle", cyc, mon_e.acc + 1);
               if (mon_e.last) expect_fd = 1'b1;
               if (int'(m_data) == target) hits++;
            end
         end
      end
   end

   initial begin
      tc[0]  = '{2'b01, 8'd0,   0, 1'b0, -1, 2'b00,   0, 32};
      tc[1]  = '{2'b10, 8'd0,   0, 1'b0, -1, 2'b00, 100, 12};
      tc[2]  = '{2'b01, 8'd0,   1, 1'b0, -1, 2'b00, 255,  4};
      tc[3]  = '{2'b11, 8'd128, 1, 1'b0, -1, 2'b00, 255,  4};
      tc[4]  = '{2'b00, 8'd0,   2, 1'b0, -1, 2'b00,  -1, -1};
      tc[5]  = '{2'b01, 8'd0,   2, 1'b1, -1, 2'b00,  -1, -1};
      tc[6]  = '{2'b10, 8'd0,   2, 1'b1, -1, 2'b00,  -1, -1};
      tc[7]  = '{2'b11, 8'd60,  1, 1'b1, -1, 2'b00, 255,  4};
      tc[8]  = '{2'b01, 8'd0,   1, 1'b0, 10, 2'b10, 255,  4};
      tc[9]  = '{2'b10, 8'd0,   1, 1'b0, -1, 2'b00,  50,  2};
      tc[10] = '{2'b00, 8'd0,   2, 1'b0, -1, 2'b00,  -1, -1};
      tc[11] = '{2'b01, 8'd0,   1, 1'b0, -1, 2'b00, 255,  4};

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check("reset_m_valid", m_valid, 0);
      check("reset_m_sof", m_sof, 0);
      check("reset_m_eol", m_eol, 0);
      check("reset_frame_done", frame_done, 0);
      check("reset_m_data", m_data, 0);
      check("reset_s_ready", s_ready, 0);
      reset = 1'b0;

      for (int k = 0; k < 10; k++) send_frame(k, NPIX);

      // Abort a frame after 13 pixels, then run a clean frame.
      send_frame(10, 13);
      reset = 1'b1;
      #1;
      check("midreset_m_valid", m_valid, 0);
      check("midreset_s_ready", s_ready, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      send_frame(11, NPIX);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/kernel3x3_stream.md
KERNEL3X3_STREAM -- requirements
Module: kernel3x3_stream

Interface
REQ-001 Parameters SHALL be: IMG_WIDTH, 640, pixels per row; IMG_HEIGHT, 480, rows per frame; PIXEL_BITS, 8, pixel width.
REQ-002 clk  input  1  clock; all registers rise-edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 mode  input  2  00 passthrough, 01 Sobel magnitude, 10 Gaussian 3x3, 11 Sobel threshold.
REQ-005 threshold  input  PIXEL_BITS  binarisation level for mode 11.
REQ-006 s_data  input  PIXEL_BITS  input pixel, raster order.
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_ready  output  1  block accepts s_data this cycle.
REQ-009 m_data  output  PIXEL_BITS  result pixel.
REQ-010 m_valid  output  1  m_data valid.
REQ-011 m_ready  input  1  sink accepts m_data.
REQ-012 m_sof  output  1  qualifies first output pixel of a frame.
REQ-013 m_eol  output  1  qualifies last output pixel of each row.
REQ-014 frame_done  output  1  single-cycle pulse after the last frame pixel leaves.

Function
REQ-015 Transfer SHALL occur on a rising edge with valid and ready both high; valid is not required to wait for ready.
REQ-016 Pipeline: stage A (window/line buffer), stage B (output register); global enable en = !m_valid || m_ready; s_ready = en && state != DRAIN.
REQ-017 Latency SHALL be 2 cycles from input acceptance to m_valid with m_ready held high; throughput 1 pixel/cycle.
REQ-018 Exactly one output per accepted input, in order; no drop or duplicate under any m_ready pattern.
REQ-019 Counters x (0..IMG_WIDTH-1) and y (0..IMG_HEIGHT-1) SHALL track the newest accepted pixel; x wraps to 0 and y increments at IMG_WIDTH-1; y wraps to 0 at frame end.
REQ-020 Window: column shift each acceptance; row 0 from line buffer 2, row 1 from line buffer 1, row 2 from s_data; line buffers updated at index x.
REQ-021 Window centre SHALL be pixel (x-1, y-1); output for an acceptance at x<2 or y<2 SHALL be 0 in modes 01/10/11.
REQ-022 Mode 00 SHALL output the newest pixel unmodified (no spatial offset, same latency).
REQ-023 Mode 01: gx, gy signed PIXEL_BITS+4 bits, standard Sobel kernels; mag = |gx|+|gy| saturated to 2^PIXEL_BITS-1.
REQ-024 Mode 10: weighted sum 1-2-1/2-4-2/1-2-1, plus 8, shifted right 4.
REQ-025 Mode 11: output all-ones when Sobel mag >= threshold, else 0.
REQ-026 mode and threshold SHALL be latched on acceptance of pixel (0,0); changes mid-frame take effect next frame.
REQ-027 FSM states: IDLE (awaiting pixel (0,0)) -> ACTIVE on its acceptance -> DRAIN on acceptance of (IMG_WIDTH-1, IMG_HEIGHT-1) -> IDLE when the last output transfers, asserting frame_done that cycle.
REQ-028 In IDLE, s_ready SHALL follow REQ-016; the first accepted pixel is always treated as (0,0).
REQ-029 m_sof/m_eol SHALL be pipelined with their pixel and held stable while m_valid && !m_ready.
REQ-030 m_data SHALL hold stable while m_valid && !m_ready.

Reset
REQ-031 Reset SHALL clear state to IDLE, x, y, m_valid, m_sof, m_eol, frame_done, m_data to 0 and latched mode to 00; s_ready SHALL be 0 during reset.
REQ-032 Reset mid-frame SHALL discard in-flight pixels; line buffer contents need not be cleared (masked by REQ-021).

Structure
REQ-033 Package kernel_stream_pkg SHALL hold the mode enum, the FSM state enum and the kernel weight constants.
REQ-034 Line buffers SHALL be one sub-module, line_buffer_2row, with a read-before-write port per row.

Verification (IMG_WIDTH=8, IMG_HEIGHT=4, PIXEL_BITS=8)
REQ-035 Constant 100 frame, mode 01 -> all 32 outputs 0; mode 10 -> interior outputs 100, border outputs 0.
REQ-036 Vertical step (cols 0-3=0, 4-7=200), mode 01 -> interior outputs 255 (saturated) at centre cols 3/4, else 0; mode 11 with threshold 128 -> 255/0 same positions.
REQ-037 Mode 00, m_ready=1 -> m_data equals s_data 2 cycles later; m_sof with output 0, m_eol every 8th, frame_done once after output 31.
REQ-038 Random s_valid and m_ready at 50% each -> output sequence identical to the zero-stall run, m_data stable while stalled.
REQ-039 mode switched 01->10 at pixel 10 -> frame filtered entirely as mode 01; next frame as mode 10.
REQ-040 reset asserted at pixel 13 then a new frame -> m_valid low within one clock, then the new frame is output correctly with m_sof on its first pixel.
